// File: rtl/canvas_mem_arbiter_pkg.sv
// Shared constants and types for the canvas RAM arbiter: requester ownership
// encoding and the read-return latency.
package canvas_mem_arbiter_pkg;

    localparam logic OWN_DISP = 1'b0;
    localparam logic OWN_CPU  = 1'b1;

    // Cycles from the ack cycle to the cycle the matching rvalid is high.
    localparam int RD_LAT = 2;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/canvas_mem_arbiter_rd_tag_pipe.sv
// Owner tag shift register: follows each read issued to the RAM and raises the
// matching requester's rvalid when the RAM data comes back.
module arb_rd_tag_pipe
    import canvas_mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic issue_valid,
    input  logic issue_owner,
    output logic disp_rvalid,
    output logic cpu_rvalid
);

    rd_tag_t                issue_tag;
    rd_tag_t [RD_LAT-1:0]   tag_reg;

    assign issue_tag = '{valid: issue_valid, owner: issue_owner};

    // Reset empties the pipe, so reads in flight never produce an rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_reg <= '0;
        end else begin
            tag_reg <= {tag_reg[RD_LAT-2:0], issue_tag};
        end
    end

    assign disp_rvalid = tag_reg[RD_LAT-1].valid && (tag_reg[RD_LAT-1].owner == OWN_DISP);
    assign cpu_rvalid  = tag_reg[RD_LAT-1].valid && (tag_reg[RD_LAT-1].owner == OWN_CPU);

endmodule

// File: rtl/canvas_mem_arbiter.sv
// Single-port canvas RAM arbiter: display line fetch has priority, the CPU is
// forced a slot after STARVE consecutive contended display wins.
module canvas_mem_arbiter
    import canvas_mem_arbiter_pkg::*;
#(
    parameter int ADDRW  = 14,
    parameter int DATAW  = 32,
    parameter int STARVE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 disp_req,
    input  logic [ADDRW-1:0]     disp_addr,
    output logic                 disp_ack,
    output logic                 disp_rvalid,
    output logic [DATAW-1:0]     disp_rdata,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDRW-1:0]     cpu_addr,
    input  logic [DATAW-1:0]     cpu_wdata,
    input  logic [DATAW/8-1:0]   cpu_wmask,
    output logic                 cpu_ack,
    output logic                 cpu_rvalid,
    output logic [DATAW-1:0]     cpu_rdata,
    output logic                 mem_ce,
    output logic                 mem_we,
    output logic [ADDRW-1:0]     mem_addr,
    output logic [DATAW-1:0]     mem_wdata,
    output logic [DATAW/8-1:0]   mem_wmask,
    input  logic [DATAW-1:0]     mem_rdata
);

    localparam int         NBYTE      = DATAW / 8;
    localparam logic [7:0] STARVE_MAX = 8'(STARVE);

    logic [7:0]       starve_reg;
    logic [7:0]       starve_next;
    logic             starve_hit;
    logic [NBYTE-1:0] cpu_mask_eff;
    logic             rd_issue;
    logic             rd_owner;

    assign starve_hit = (starve_reg == STARVE_MAX);
    assign disp_ack   = disp_req & ~(cpu_req & starve_hit);
    assign cpu_ack    = cpu_req & (~disp_req | starve_hit);

    // Counts only display wins the CPU actually had to wait for.
    always_comb begin
        starve_next = starve_reg;
        if (!cpu_req || cpu_ack) begin
            starve_next = '0;
        end else if (disp_ack && !starve_hit) begin
            starve_next = starve_reg + 8'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBYTE; gi++) begin : g_mask
            assign cpu_mask_eff[gi] = cpu_we & cpu_wmask[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_reg <= '0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
        end else begin
            starve_reg <= starve_next;
            if (disp_ack) begin
                mem_ce    <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= disp_addr;
                mem_wdata <= '0;
                mem_wmask <= '0;
            end else if (cpu_ack) begin
                mem_ce    <= 1'b1;
                mem_we    <= cpu_we;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                mem_wmask <= cpu_mask_eff;
            end else begin
                mem_ce    <= 1'b0;
                mem_we    <= 1'b0;
            end
        end
    end

    // Writes, including zero-mask ones, never enter the tag pipe.
    assign rd_issue = disp_ack | (cpu_ack & ~cpu_we);
    assign rd_owner = cpu_ack ? OWN_CPU : OWN_DISP;

    arb_rd_tag_pipe u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (rd_issue),
        .issue_owner (rd_owner),
        .disp_rvalid (disp_rvalid),
        .cpu_rvalid  (cpu_rvalid)
    );

    assign disp_rdata = mem_rdata;
    assign cpu_rdata  = mem_rdata;

endmodule
